// File: rtl/simon_pkg.sv
// simon_pkg: shared definitions for the SIMON iterative core.
//   Z_SEQ   : the five published 62-bit z sequences; index 0 is the leftmost bit.
//   state_t : control FSM states.
//   rotl/rotr : rotate a word of width n held in the low bits of a 64-bit value.
package simon_pkg;

  localparam logic [0:4][0:61] Z_SEQ = {
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Words narrower than 64 bits live in the low bits; upper bits are cleared.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned n,
                                       input int unsigned k);
    logic [63:0] m;
    logic [63:0] w;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    w = v & m;
    return ((w << k) | (w >> (n - k))) & m;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n,
                                       input int unsigned k);
    return rotl(v, n, n - k);
  endfunction

endpackage

// File: rtl/simon_iter_core_if.sv
// simon_iter_core_if: block input / ciphertext output handshake bundle.
//   in_valid/in_ready/pt/key : block acceptance (pt/key sampled on accept)
//   out_valid/out_ready/ct   : ciphertext delivery
//   Vectors use bit 0 as MSB.
//   slave modport = the core, master modport = the producer/consumer.
interface simon_iter_core_if #(
  parameter int WORD      = 32,
  parameter int KEY_WORDS = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [0:2*WORD-1]            pt;
  logic [0:KEY_WORDS*WORD-1]    key;
  logic                         out_valid;
  logic                         out_ready;
  logic [0:2*WORD-1]            ct;

  modport slave  (input  in_valid, pt, key, out_ready,
                  output in_ready, out_valid, ct);
  modport master (output in_valid, pt, key, out_ready,
                  input  in_ready, out_valid, ct);
endinterface

// File: rtl/simon_key_step.sv
// simon_key_step: combinational SIMON key expansion, one new round key.
//   kr0   : oldest key word k_i
//   kr1   : k_{i+1} (used only for 4-word keys)
//   klast : newest key word k_{i+m-1}
//   zbit  : current z-sequence bit
//   knext : k_{i+m}
module simon_key_step import simon_pkg::*; #(
  parameter int WORD      = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic [WORD-1:0] kr0,
  input  logic [WORD-1:0] kr1,
  input  logic [WORD-1:0] klast,
  input  logic            zbit,
  output logic [WORD-1:0] knext
);
  logic [WORD-1:0] t;

  always_comb begin
    t = WORD'(rotr(64'(klast), WORD, 3));
    if (KEY_WORDS == 4) t = t ^ kr1;
    t = t ^ WORD'(rotr(64'(t), WORD, 1));
    // ~k_i ^ 3 is the published constant c = 2^n - 4 folded with k_i
    knext = ~kr0 ^ t ^ WORD'(zbit) ^ WORD'(3);
  end
endmodule

// File: rtl/simon_iter_core.sv
// simon_iter_core: iterative SIMON encryption core (default SIMON64/128).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : simon_iter_core_if slave (pt/key in, ct out, valid/ready both ways)
//   busy       : high while rounds are running
// Build option: define SIMON_UNROLL2_EN for two rounds per cycle (ROUNDS must
// be even); ciphertext is identical either way.
module simon_iter_core import simon_pkg::*; #(
  parameter int WORD      = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 44,
  parameter int Z_IDX     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  simon_iter_core_if.slave bus,
  output logic             busy
);
  localparam int RW = $clog2(ROUNDS + 1);
`ifdef SIMON_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [0:61] ZC = Z_SEQ[Z_IDX];

  state_t          state, state_n;
  logic [WORD-1:0] x, y, x_n, y_n;
  logic [WORD-1:0] kr   [KEY_WORDS];
  logic [WORD-1:0] kr_n [KEY_WORDS];
  logic [RW-1:0]   rc;
  logic [5:0]      zi, zi_n;
  logic [WORD-1:0] k_m0;
  logic            last_round;

  function automatic logic [WORD-1:0] rl(input logic [WORD-1:0] v, input int unsigned s);
    return WORD'(rotl(64'(v), WORD, s));
  endfunction

  function automatic logic [WORD-1:0] f(input logic [WORD-1:0] v);
    return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
  endfunction

  function automatic logic [5:0] zinc(input logic [5:0] z);
    return (z == 6'd61) ? '0 : z + 6'd1;
  endfunction

  simon_key_step #(.WORD(WORD), .KEY_WORDS(KEY_WORDS)) u_ks0 (
    .kr0   (kr[0]),
    .kr1   (kr[1]),
    .klast (kr[KEY_WORDS-1]),
    .zbit  (ZC[zi]),
    .knext (k_m0)
  );

`ifdef SIMON_UNROLL2_EN
  logic [WORD-1:0] kr_s1 [KEY_WORDS];
  logic [WORD-1:0] k_m1, x1;
  logic [5:0]      zi1;

  assign zi1 = zinc(zi);

  // Key window after the first expansion feeds the second expansion.
  always_comb begin
    kr_s1[KEY_WORDS-1] = k_m0;
    for (int unsigned j = 0; j < KEY_WORDS - 1; j++) kr_s1[j] = kr[j+1];
  end

  simon_key_step #(.WORD(WORD), .KEY_WORDS(KEY_WORDS)) u_ks1 (
    .kr0   (kr_s1[0]),
    .kr1   (kr_s1[1]),
    .klast (kr_s1[KEY_WORDS-1]),
    .zbit  (ZC[zi1]),
    .knext (k_m1)
  );

  always_comb begin
    x1   = y ^ f(x) ^ kr[0];
    x_n  = x ^ f(x1) ^ kr[1];
    y_n  = x1;
    kr_n[KEY_WORDS-1] = k_m1;
    for (int unsigned j = 0; j < KEY_WORDS - 1; j++) kr_n[j] = kr_s1[j+1];
    zi_n = zinc(zi1);
    last_round = (rc == RW'(ROUNDS - 2));
  end
`else
  always_comb begin
    x_n  = y ^ f(x) ^ kr[0];
    y_n  = x;
    kr_n[KEY_WORDS-1] = k_m0;
    for (int unsigned j = 0; j < KEY_WORDS - 1; j++) kr_n[j] = kr[j+1];
    zi_n = zinc(zi);
    last_round = (rc == RW'(ROUNDS - 1));
  end
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_n = RUN;
      RUN:     if (last_round)    state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      rc    <= '0;
      zi    <= '0;
      for (int unsigned j = 0; j < KEY_WORDS; j++) kr[j] <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          x  <= bus.pt[0:WORD-1];
          y  <= bus.pt[WORD:2*WORD-1];
          rc <= '0;
          zi <= '0;
          // key packs k[m-1] first, so k0 is the last word
          for (int unsigned j = 0; j < KEY_WORDS; j++)
            kr[j] <= bus.key[(KEY_WORDS-1-j)*WORD +: WORD];
        end
        RUN: begin
          x  <= x_n;
          y  <= y_n;
          rc <= rc + RW'(STEP);
          zi <= zi_n;
          for (int unsigned j = 0; j < KEY_WORDS; j++) kr[j] <= kr_n[j];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ct        = (state == DONE) ? {x, y} : '0;
  assign busy          = (state == RUN);

endmodule

// File: tb/tb_simon_iter_core.sv
module tb_simon_iter_core;

`ifdef SIMON_UNROLL2_EN
  localparam int LAT   = 22;
  localparam int LAT16 = 16;
`else
  localparam int LAT   = 44;
  localparam int LAT16 = 32;
`endif

  localparam logic [61:0] ZT [0:4] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy16;
  int   checks = 0;
  int   failures = 0;

  simon_iter_core_if #(.WORD(32), .KEY_WORDS(4)) bus ();
  simon_iter_core_if #(.WORD(16), .KEY_WORDS(4)) bus16 ();

  simon_iter_core #(.WORD(32), .KEY_WORDS(4), .ROUNDS(44), .Z_IDX(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));
  simon_iter_core #(.WORD(16), .KEY_WORDS(4), .ROUNDS(32), .Z_IDX(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave), .busy(busy16));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference SIMON encryption: full key schedule first, then all rounds.
  function automatic logic [127:0] model(input logic [127:0] p, input logic [255:0] kin,
                                         input int n, input int m, input int t_rounds,
                                         input int zsel);
    logic [63:0] msk, x, y, t, tmp;
    logic [63:0] k [0:127];
    logic [61:0] zs;
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    zs  = ZT[zsel];
    for (int j = 0; j < m; j++) k[j] = 64'(kin >> (j * n)) & msk;
    for (int i = m; i < t_rounds; i++) begin
      t = ((k[i-1] >> 3) | (k[i-1] << (n - 3))) & msk;
      if (m == 4) t = t ^ k[i-3];
      t = t ^ (((t >> 1) | (t << (n - 1))) & msk);
      k[i] = (~k[i-m] ^ t ^ 64'(zs[61 - ((i - m) % 62)]) ^ 64'd3) & msk;
    end
    x = 64'(p >> n) & msk;
    y = 64'(p) & msk;
    for (int i = 0; i < t_rounds; i++) begin
      tmp = x;
      x = (y ^ ((((x << 1) | (x >> (n - 1))) & ((x << 8) | (x >> (n - 8))))
               ^ ((x << 2) | (x >> (n - 2)))) ^ k[i]) & msk;
      y = tmp;
    end
    return 128'((x << n) | y);
  endfunction

  function automatic logic [63:0] ref64(input logic [63:0] p, input logic [127:0] k);
    logic [127:0] r;
    r = model({64'b0, p}, {128'b0, k}, 32, 4, 44, 3);
    return r[63:0];
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] p, input logic [63:0] k);
    logic [127:0] r;
    r = model({96'b0, p}, {192'b0, k}, 16, 4, 32, 0);
    return r[31:0];
  endfunction

  // Present a block to the 64/128 core; returns #1 after the accept edge.
  task automatic start_block(input logic [63:0] p, input logic [127:0] k);
    @(negedge clk);
    bus.pt = p;
    bus.key = k;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid (capped at 200).
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.ct !== 64'h0) begin failures++; $display("FAIL reset_ct: got %h expected 0", bus.ct); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready16: got %b expected 1", bus16.in_ready); end
  endtask

  task automatic test_kat(input string tag);
    int cyc;
    start_block(64'h656b696c_20646e75, 128'h1b1a1918_13121110_0b0a0908_03020100);
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL %s_run_flags: got busy=%b in_ready=%b expected 1/0", tag, busy, bus.in_ready); end
    wait_out(cyc);
    checks++;
    if (cyc != LAT) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", tag, cyc, LAT); end
    checks++;
    if (bus.ct !== 64'h44c8fc20_b9dfa07a) begin failures++; $display("FAIL %s_ct: got %h expected 44c8fc20b9dfa07a", tag, bus.ct); end
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL %s_done_flags: got busy=%b in_ready=%b expected 0/0", tag, busy, bus.in_ready); end
    handshake();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_after_hs: got out_valid=%b in_ready=%b expected 0/1", tag, bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [63:0]  p, e;
    logic [127:0] k;
    p = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    e = ref64(p, k);
    start_block(p, k);
    wait_out(cyc);
    checks++;
    if (cyc != LAT) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", cyc, LAT); end
    bus.pt = ~p;
    bus.key = ~k;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ct !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got ct=%h out_valid=%b in_ready=%b expected ct=%h 1 0", i, bus.ct, bus.out_valid, bus.in_ready, e);
      end
    end
    bus.in_valid = 1'b0;
    handshake();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ignored_in_valid: got busy=%b in_ready=%b expected 0/1", busy, bus.in_ready); end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    start_block(64'h0123_4567_89ab_cdef, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ct !== 64'h0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reset: got out_valid=%b ct=%h busy=%b in_ready=%b expected 0 0 0 1", bus.out_valid, bus.ct, busy, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrun_discard: got activity=%b expected 0", seen); end
    test_kat("after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0]  pa, pb, ea, eb;
    logic [127:0] ka, kb;
    pa = {$urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    ea = ref64(pa, ka);
    eb = ref64(pb, kb);
    bus.out_ready = 1'b1;
    start_block(pa, ka);
    wait_out(cyc);
    checks++;
    if (bus.ct !== ea) begin failures++; $display("FAIL b2b_ct_a: got %h expected %h", bus.ct, ea); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_ready_a: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
    start_block(pb, kb);
    wait_out(cyc);
    checks++;
    if (cyc != LAT) begin failures++; $display("FAIL b2b_latency_b: got %0d expected %0d", cyc, LAT); end
    checks++;
    if (bus.ct !== eb) begin failures++; $display("FAIL b2b_ct_b: got %h expected %h", bus.ct, eb); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_b: got in_ready=%b expected 1", bus.in_ready); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int cyc;
    logic [63:0]  p, e;
    logic [127:0] k;
    for (int n = 0; n < 8; n++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      e = ref64(p, k);
      start_block(p, k);
      wait_out(cyc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (bus.ct !== e || cyc != LAT) begin failures++; $display("FAIL random_%0d: got ct=%h lat=%0d expected ct=%h lat=%0d", n, bus.ct, cyc, e, LAT); end
      handshake();
    end
  endtask

  task automatic test_simon32();
    int cyc;
    logic [31:0] p, e;
    logic [63:0] k;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin
        p = 32'h6565_6877;
        k = 64'h1918_1110_0908_0100;
        e = 32'hc69b_e9bb;
      end else begin
        p = $urandom;
        k = {$urandom, $urandom};
        e = ref32(p, k);
      end
      @(negedge clk);
      bus16.pt = p;
      bus16.key = k;
      bus16.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      cyc = 0;
      while (bus16.out_valid !== 1'b1 && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      checks++;
      if (bus16.ct !== e || cyc != LAT16) begin failures++; $display("FAIL simon32_%0d: got ct=%h lat=%0d expected ct=%h lat=%0d", n, bus16.ct, cyc, e, LAT16); end
      bus16.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus16.out_ready = 1'b0;
      checks++;
      if (bus16.in_ready !== 1'b1 || busy16 !== 1'b0) begin failures++; $display("FAIL simon32_idle_%0d: got in_ready=%b busy=%b expected 1/0", n, bus16.in_ready, busy16); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.pt = '0;
    bus.key = '0;
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.pt = '0;
    bus16.key = '0;
    test_reset();
    test_kat("kat");
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    test_simon32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
